// File: rtl/dma_peripheral_requester.sv
// Peripheral-side DMA initiator: buffers device bytes in a small FIFO and
// streams them to memory in bus-granted bursts of at most BURST_LEN beats.
module dma_peripheral_requester #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              dev_valid,
  input  logic [DATA_W-1:0] dev_data,
  output logic              dev_ready,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [7:0]        cfg_count,
  output logic              DMA_REQUEST,
  input  logic              DMA_ACK,
  output logic [DATA_W-1:0] DMA_DATA,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              DMA_WE,
  output logic              busy,
  output logic              done,
  output logic [7:0]        remaining
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BEAT_W = $clog2(BURST_LEN + 1);
  localparam int unsigned REM_W  = 8;

  typedef enum logic [2:0] {
    IDLE, WAIT_DATA, REQ, XFER, RELEASE, DONE
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    fifo_count;
  logic [ADDR_W-1:0]   addr;
  logic [BEAT_W-1:0]   beats_left;
  logic                full;
  logic                push;
  logic                pop;
  logic [REM_W-1:0]    burst_n;

  assign full      = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign dev_ready = !full;
  assign push      = dev_valid && !full;
  // A beat is issued (and the FIFO popped) only while holding the bus and granted
  assign pop       = ((state == REQ) || (state == XFER)) && DMA_ACK && (beats_left != '0);
  assign burst_n   = (remaining < REM_W'(BURST_LEN)) ? remaining : REM_W'(BURST_LEN);

  // FIFO storage, no reset needed: occupancy is tracked by the pointers
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= dev_data;
  end

  // Control FSM, FIFO pointers and registered bus outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      addr        <= '0;
      beats_left  <= '0;
      DMA_REQUEST <= 1'b0;
      DMA_DATA    <= '0;
      MEM_ADDR    <= '0;
      DMA_WE      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      remaining   <= '0;
    end else begin
      DMA_WE <= 1'b0;
      done   <= 1'b0;

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: ;
      endcase

      unique case (state)
        IDLE: begin
          if (cfg_start) begin
            addr      <= cfg_base_addr;
            remaining <= cfg_count;
            busy      <= 1'b1;
            if (cfg_count == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= WAIT_DATA;
            end
          end
        end
        WAIT_DATA: begin
          // Only request the bus once the whole burst is already buffered
          if (REM_W'(fifo_count) >= burst_n) begin
            DMA_REQUEST <= 1'b1;
            beats_left  <= BEAT_W'(burst_n);
            state       <= REQ;
          end
        end
        REQ, XFER: begin
          if (pop) begin
            DMA_WE     <= 1'b1;
            DMA_DATA   <= mem[rd_ptr];
            MEM_ADDR   <= addr;
            addr       <= addr + ADDR_W'(1);
            remaining  <= remaining - REM_W'(1);
            beats_left <= beats_left - BEAT_W'(1);
            if (beats_left == BEAT_W'(1)) begin
              DMA_REQUEST <= 1'b0;
              state       <= RELEASE;
            end else begin
              state <= XFER;
            end
          end
        end
        RELEASE: begin
          if (!DMA_ACK) begin
            if (remaining != '0) begin
              state <= WAIT_DATA;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_peripheral_requester.sv
// Directed bench for dma_peripheral_requester: device bytes and target addresses
// are scoreboarded and matched against every DMA_WE beat.
module tb_dma_peripheral_requester;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       dev_valid;
  logic [7:0] dev_data;
  logic       dev_ready;
  logic       cfg_start;
  logic [7:0] cfg_base_addr;
  logic [7:0] cfg_count;
  logic       DMA_REQUEST;
  logic       DMA_ACK;
  logic [7:0] DMA_DATA;
  logic [7:0] MEM_ADDR;
  logic       DMA_WE;
  logic       busy;
  logic       done;
  logic [7:0] remaining;

  dma_peripheral_requester #(
    .DATA_W(8), .ADDR_W(8), .FIFO_DEPTH(8), .BURST_LEN(4)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .dev_valid(dev_valid), .dev_data(dev_data), .dev_ready(dev_ready),
    .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr), .cfg_count(cfg_count),
    .DMA_REQUEST(DMA_REQUEST), .DMA_ACK(DMA_ACK), .DMA_DATA(DMA_DATA),
    .MEM_ADDR(MEM_ADDR), .DMA_WE(DMA_WE),
    .busy(busy), .done(done), .remaining(remaining)
  );

  always #5 CLK = ~CLK;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] src_q[$];
  logic [7:0] fifo_q[$];
  logic [7:0] exp_addr;
  int         bursts[$];
  int         cur_burst;
  int         done_seen;
  int         gap_cycles;
  int         beats_total;
  int         drop_cnt;
  bit         drop_armed;
  bit         prev_req;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: offer a device byte, sample after the edge, score beats, drive the grant
  task automatic tick();
    bit         acc;
    bit         ack_before;
    logic [7:0] d;
    dev_valid = (src_q.size() > 0);
    if (dev_valid) dev_data = src_q[0];
    acc = dev_valid && dev_ready && !RESET;
    ack_before = DMA_ACK;
    @(posedge CLK);
    #1;
    if (acc) fifo_q.push_back(src_q.pop_front());
    if (DMA_REQUEST && !prev_req) check("req_rise_ack_low", 32'(ack_before), 32'd0);
    if (DMA_WE) begin
      cur_burst++;
      beats_total++;
      check("beat_data_avail", 32'(fifo_q.size() > 0), 32'd1);
      if (fifo_q.size() > 0) begin
        d = fifo_q.pop_front();
        check("beat_data", 32'(DMA_DATA), 32'(d));
      end
      check("beat_addr", 32'(MEM_ADDR), 32'(exp_addr));
      exp_addr++;
      if (!DMA_REQUEST) begin
        bursts.push_back(cur_burst);
        cur_burst = 0;
      end else if (drop_armed && cur_burst == 1) begin
        drop_armed = 1'b0;
        drop_cnt   = 3;
      end
    end else if (DMA_REQUEST && cur_burst > 0) begin
      gap_cycles++;
    end
    if (done) done_seen++;
    prev_req = DMA_REQUEST;
    if (drop_cnt > 0) begin
      DMA_ACK = 1'b0;
      drop_cnt--;
    end else begin
      DMA_ACK = DMA_REQUEST;
    end
  endtask

  task automatic new_test();
    bursts.delete();
    cur_burst   = 0;
    done_seen   = 0;
    gap_cycles  = 0;
    beats_total = 0;
  endtask

  task automatic start(input logic [7:0] base, input logic [7:0] cnt);
    exp_addr      = base;
    cfg_base_addr = base;
    cfg_count     = cnt;
    cfg_start     = 1'b1;
    tick();
    cfg_start     = 1'b0;
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic check_bursts(input string tag, input int n, input int b0, input int b1, input int b2);
    int b[3];
    b[0] = b0; b[1] = b1; b[2] = b2;
    check({tag, "_nbursts"}, bursts.size(), n);
    for (int i = 0; i < n && i < bursts.size(); i++)
      check($sformatf("%s_burst%0d", tag, i), bursts[i], b[i]);
  endtask

  task automatic fill_src(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) src_q.push_back(first + 8'(i));
  endtask

  initial begin
    RESET = 1'b1; dev_valid = 1'b0; dev_data = '0; cfg_start = 1'b0;
    cfg_base_addr = '0; cfg_count = '0; DMA_ACK = 1'b0;
    prev_req = 1'b0; drop_cnt = 0; drop_armed = 1'b0; exp_addr = '0;
    new_test();
    repeat (2) @(posedge CLK);
    #1;
    check("rst_req", 32'(DMA_REQUEST), 32'd0);
    check("rst_we", 32'(DMA_WE), 32'd0);
    check("rst_data", 32'(DMA_DATA), 32'd0);
    check("rst_addr", 32'(MEM_ADDR), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rem", 32'(remaining), 32'd0);
    check("rst_ready", 32'(dev_ready), 32'd1);
    RESET = 1'b0;
    tick();

    // Prefilled single burst
    new_test();
    fill_src(8'hA0, 4);
    repeat (6) tick();
    check("t1_idle_busy", 32'(busy), 32'd0);
    check("t1_idle_req", 32'(DMA_REQUEST), 32'd0);
    start(8'h10, 8'd4);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_rem_start", 32'(remaining), 32'd4);
    run_until_idle("t1", 100);
    check("t1_done_cnt", done_seen, 1);
    check("t1_rem_end", 32'(remaining), 32'd0);
    check("t1_gap", gap_cycles, 0);
    check_bursts("t1", 1, 4, 0, 0);

    // Streaming device, three grants
    new_test();
    fill_src(8'hB0, 10);
    start(8'h40, 8'd10);
    run_until_idle("t2", 200);
    check("t2_done_cnt", done_seen, 1);
    check("t2_beats", beats_total, 10);
    check_bursts("t2", 3, 4, 4, 2);

    // Grant withdrawn for three cycles after the first beat
    new_test();
    fill_src(8'hC0, 4);
    repeat (5) tick();
    drop_armed = 1'b1;
    start(8'h80, 8'd4);
    run_until_idle("t3", 100);
    check("t3_gap", gap_cycles, 3);
    check("t3_beats", beats_total, 4);
    check_bursts("t3", 1, 4, 0, 0);

    // Address wrap; outputs hold last beat afterwards
    new_test();
    fill_src(8'hE0, 4);
    start(8'hFE, 8'd4);
    run_until_idle("t4", 100);
    check("t4_hold_addr", 32'(MEM_ADDR), 32'h01);
    check("t4_hold_data", 32'(DMA_DATA), 32'hE3);
    check("t4_beats", beats_total, 4);

    // Zero-length transfer
    new_test();
    start(8'h55, 8'd0);
    check("t5_done_now", 32'(done), 32'd1);
    check("t5_busy_now", 32'(busy), 32'd1);
    check("t5_req", 32'(DMA_REQUEST), 32'd0);
    tick();
    check("t5_done_gone", 32'(done), 32'd0);
    check("t5_idle", 32'(busy), 32'd0);
    check("t5_done_cnt", done_seen, 1);

    // Start while busy is ignored
    new_test();
    start(8'h20, 8'd5);
    check("t5b_rem", 32'(remaining), 32'd5);
    cfg_base_addr = 8'h99;
    cfg_count     = 8'd9;
    cfg_start     = 1'b1;
    tick();
    cfg_start     = 1'b0;
    check("t5b_rem_kept", 32'(remaining), 32'd5);
    check("t5b_no_req", 32'(DMA_REQUEST), 32'd0);
    fill_src(8'h60, 5);
    run_until_idle("t5b", 100);
    check("t5b_done_cnt", done_seen, 1);
    check_bursts("t5b", 2, 4, 1, 0);

    // Full FIFO, then reset in the middle of a burst
    new_test();
    fill_src(8'hD0, 9);
    repeat (12) tick();
    check("t6_full_ready", 32'(dev_ready), 32'd0);
    check("t6_refused", src_q.size(), 1);
    src_q.delete();
    start(8'h00, 8'd8);
    for (int n = 0; n < 20 && !DMA_WE; n++) tick();
    check("t6_in_xfer", 32'(DMA_WE), 32'd1);
    #2;
    RESET = 1'b1;
    #1;
    check("t6_rst_req", 32'(DMA_REQUEST), 32'd0);
    check("t6_rst_we", 32'(DMA_WE), 32'd0);
    check("t6_rst_data", 32'(DMA_DATA), 32'd0);
    check("t6_rst_addr", 32'(MEM_ADDR), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_rem", 32'(remaining), 32'd0);
    check("t6_rst_ready", 32'(dev_ready), 32'd1);
    fifo_q.delete();
    cur_burst = 0;
    repeat (3) tick();
    RESET = 1'b0;
    tick();
    check("t6_no_done", done_seen, 0);
    check("t6_idle", 32'(busy), 32'd0);

    // Normal operation after the aborted transfer
    new_test();
    fill_src(8'h70, 2);
    start(8'h30, 8'd2);
    run_until_idle("t7", 100);
    check("t7_done_cnt", done_seen, 1);
    check_bursts("t7", 1, 2, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
